// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // LSB position of port `port` in a packed bus of `w`-bit fields.
    function automatic int port_lsb(input int port, input int w);
        return port * w;
    endfunction
endpackage

// File: rtl/regfile_if.sv
// Issue/writeback-side bus of regfile_sb: write port, read ports, scoreboard set, clear handshake.
interface regfile_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                    wr_en;
    logic                    wr_ready;
    logic [AW-1:0]           wr_addr;
    logic                    wr_src;
    logic [WIDTH-1:0]        wr_data;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_pend;
    logic                    sb_set;
    logic [AW-1:0]           sb_addr;
    logic                    clr_req;
    logic                    clr_busy;

    modport master (
        output wr_en, wr_addr, wr_src, wr_data, rd_addr, sb_set, sb_addr, clr_req,
        input  wr_ready, rd_data, rd_pend, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_src, wr_data, rd_addr, sb_set, sb_addr, clr_req,
        output wr_ready, rd_data, rd_pend, clr_busy
    );
endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every register index once, one per cycle, then returns to IDLE.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);
    clr_state_t    state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Requests arriving while CLEAR is running are ignored; only IDLE samples clr_req.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + 1'b1;
                if (idx == AW'(DEPTH - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_busy = (state == CLEAR);
    assign clr_we   = (state == CLEAR);
    assign clr_idx  = idx;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard, sequenced clear and move path.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle wr_data (non-move) to reads and taps.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic             clk,
    input  logic             rst,
    regfile_if.slave         bus,
    output logic [WIDTH-1:0] tap0,
    output logic [WIDTH-1:0] tap1
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            sb;
    logic                        clr_busy, clr_we;
    logic [AW-1:0]               clr_idx;
    logic                        wr_acc;
    logic [AW-1:0]               rd0_addr;
    logic [WIDTH-1:0]            wdata;

    regfile_clr_seq #(.DEPTH(DEPTH)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    assign bus.clr_busy = clr_busy;
    assign bus.wr_ready = ~clr_busy;
    assign wr_acc       = bus.wr_en & ~clr_busy;

    // Move source is the stored port-0 value, never the bypassed one, so no loop through rd_data.
    assign rd0_addr = bus.rd_addr[AW-1:0];
    assign wdata    = bus.wr_src ? mem[rd0_addr] : bus.wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
            sb  <= '0;
        end else if (clr_we) begin
            mem[clr_idx] <= '0;
            sb[clr_idx]  <= 1'b0;
        end else begin
            if (wr_acc) begin
                mem[bus.wr_addr] <= wdata;
                sb[bus.wr_addr]  <= 1'b0;
            end
            // Ordered after the write clear so a same-address set wins.
            if (bus.sb_set) sb[bus.sb_addr] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        assign ra = bus.rd_addr[port_lsb(p, AW) +: AW];
`ifdef REGFILE_BYPASS_EN
        assign hit = wr_acc & ~bus.wr_src & (bus.wr_addr == ra);
`else
        assign hit = 1'b0;
`endif
        assign bus.rd_data[port_lsb(p, WIDTH) +: WIDTH] = hit ? bus.wr_data : mem[ra];
        assign bus.rd_pend[p] = hit ? (bus.sb_set & (bus.sb_addr == ra)) : sb[ra];
    end

`ifdef REGFILE_BYPASS_EN
    assign tap0 = (wr_acc & ~bus.wr_src & (bus.wr_addr == AW'(0))) ? bus.wr_data : mem[0];
    assign tap1 = (wr_acc & ~bus.wr_src & (bus.wr_addr == AW'(1))) ? bus.wr_data : mem[1];
`else
    assign tap0 = mem[0];
    assign tap1 = mem[1];
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic vs a register-array model.
module tb_regfile_sb;
    localparam int W = 32;
    localparam int D = 8;
    localparam int R = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] tap0, tap1;
    int           checks = 0;
    int           errors = 0;

    regfile_if #(.WIDTH(W), .DEPTH(D), .NUM_RD(R)) bus ();

    regfile_sb #(.WIDTH(W), .DEPTH(D), .NUM_RD(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tap0 (tap0),
        .tap1 (tap1)
    );

    always #5 clk = ~clk;

    // Reference: architectural register contents, pending bits, and cycles of clearing left.
    logic [W-1:0] mreg [D];
    bit           msb  [D];
    int           clr_left = 0;

    function automatic logic [W-1:0] exp_rd(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && clr_left == 0 && !bus.wr_src && bus.wr_addr == a) return bus.wr_data;
`endif
        return mreg[a];
    endfunction

    function automatic logic exp_pd(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && clr_left == 0 && !bus.wr_src && bus.wr_addr == a)
            return bus.sb_set && bus.sb_addr == a;
`endif
        return msb[a];
    endfunction

    task automatic idle_in();
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_src = 0; bus.wr_data = 0;
        bus.rd_addr = 0; bus.sb_set = 0; bus.sb_addr = 0; bus.clr_req = 0;
    endtask

    task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < D; i++) begin mreg[i] = '0; msb[i] = 0; end
            clr_left = 0;
        end else if (clr_left > 0) begin
            mreg[D - clr_left] = '0;
            msb[D - clr_left]  = 0;
            clr_left--;
        end else begin
            if (bus.wr_en) begin
                mreg[bus.wr_addr] = bus.wr_src ? mreg[bus.rd_addr[2:0]] : bus.wr_data;
                msb[bus.wr_addr]  = 0;
            end
            if (bus.sb_set) msb[bus.sb_addr] = 1;
            if (bus.clr_req) clr_left = D;
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        idle_in();
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.clr_busy); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.wr_ready); end
        checks++; if (tap0 !== '0 || tap1 !== '0) begin errors++; $display("FAIL reset_taps got %h %h exp 0 0", tap0, tap1); end
        checks++; if (bus.rd_data !== '0 || bus.rd_pend !== '0) begin errors++; $display("FAIL reset_rd got %h/%b exp 0/0", bus.rd_data, bus.rd_pend); end
    endtask

    task automatic test_write_read();
        wr(3, 32'hDEADBEEF);
        wr(5, 32'h12345678);
        set_rd(3, 5);
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_p0 got %h exp deadbeef", bus.rd_data[31:0]); end
        checks++; if (bus.rd_data[63:32] !== 32'h12345678) begin errors++; $display("FAIL wr_rd_p1 got %h exp 12345678", bus.rd_data[63:32]); end
        checks++; if (tap0 !== '0 || tap1 !== '0) begin errors++; $display("FAIL wr_rd_taps got %h %h exp 0 0", tap0, tap1); end
    endtask

    task automatic test_move();
        wr(2, 32'hA5A5A5A5);
        bus.wr_en = 1; bus.wr_src = 1; bus.wr_addr = 6; bus.wr_data = 32'h0BADBAD0;
        set_rd(2, 0);
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL move_same_cycle got %h exp a5a5a5a5", bus.rd_data[31:0]); end
        tick();
        idle_in();
        set_rd(6, 2);
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL move_dst got %h exp a5a5a5a5", bus.rd_data[31:0]); end
        checks++; if (bus.rd_data[63:32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL move_src got %h exp a5a5a5a5", bus.rd_data[63:32]); end
    endtask

    task automatic test_scoreboard();
        idle_in(); bus.sb_set = 1; bus.sb_addr = 4; tick(); idle_in();
        set_rd(4, 0); #1;
        checks++; if (bus.rd_pend !== 2'b01) begin errors++; $display("FAIL sb_set got %b exp 01", bus.rd_pend); end
        wr(4, 32'h44);
        set_rd(4, 0); #1;
        checks++; if (bus.rd_pend[0] !== 1'b0) begin errors++; $display("FAIL sb_wr_clear got %b exp 0", bus.rd_pend[0]); end
        bus.wr_en = 1; bus.wr_addr = 4; bus.wr_data = 32'h45; bus.sb_set = 1; bus.sb_addr = 4;
        tick(); idle_in();
        set_rd(4, 0); #1;
        checks++; if (bus.rd_pend[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", bus.rd_pend[0]); end
        bus.wr_en = 1; bus.wr_addr = 4; bus.wr_data = 32'h46; bus.sb_set = 1; bus.sb_addr = 6;
        tick(); idle_in();
        set_rd(4, 6); #1;
        checks++; if (bus.rd_pend !== 2'b10) begin errors++; $display("FAIL sb_diff_addr got %b exp 10", bus.rd_pend); end
    endtask

    task automatic test_bypass();
        logic [W-1:0] want;
        wr(3, 32'h11111111);
        bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 32'hCAFEF00D;
        set_rd(0, 3);
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'hCAFEF00D;
`else
        want = 32'h11111111;
`endif
        checks++; if (bus.rd_data[63:32] !== want) begin errors++; $display("FAIL bypass_p1 got %h exp %h", bus.rd_data[63:32], want); end
        tick(); idle_in();
        set_rd(0, 3); #1;
        checks++; if (bus.rd_data[63:32] !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_after got %h exp cafef00d", bus.rd_data[63:32]); end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        for (int i = 0; i < D; i++) wr(3'(i), 32'h1000 + i * 32'h11);
        for (int i = 0; i < D; i++) begin
            idle_in(); bus.sb_set = 1; bus.sb_addr = 3'(i); tick();
        end
        idle_in(); bus.clr_req = 1; tick(); idle_in();
        for (int c = 0; c < 12; c++) begin
            if (c == 3) begin bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 32'hFFFFFFFF; end
            #1;
            if (bus.clr_busy === 1'b1) busy_cnt++;
            checks++;
            if (bus.clr_busy !== (clr_left > 0) || bus.wr_ready !== (clr_left == 0)) begin
                errors++; $display("FAIL clr_cycle%0d busy/ready got %b/%b exp %b/%b", c, bus.clr_busy, bus.wr_ready, clr_left > 0, clr_left == 0);
            end
            tick(); idle_in();
        end
        checks++; if (busy_cnt != D) begin errors++; $display("FAIL clr_len got %0d exp %0d", busy_cnt, D); end
        for (int a = 0; a < D; a++) begin
            set_rd(3'(a), 3'(a)); #1;
            checks++;
            if (bus.rd_data !== '0 || bus.rd_pend !== '0) begin
                errors++; $display("FAIL clr_reg%0d got %h/%b exp 0/0", a, bus.rd_data, bus.rd_pend);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        wr(1, 32'h77); wr(5, 32'h55);
        idle_in(); bus.sb_set = 1; bus.sb_addr = 5; tick();
        idle_in(); bus.clr_req = 1; tick(); idle_in();
        tick(); tick(); tick();
        rst = 1; tick(); rst = 0;
        #1;
        checks++; if (bus.clr_busy !== 1'b0 || bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rstclr_busy got %b/%b exp 0/1", bus.clr_busy, bus.wr_ready); end
        for (int a = 0; a < D; a++) begin
            set_rd(3'(a), 3'(a)); #1;
            checks++;
            if (bus.rd_data !== '0 || bus.rd_pend !== '0) begin
                errors++; $display("FAIL rstclr_reg%0d got %h/%b exp 0/0", a, bus.rd_data, bus.rd_pend);
            end
        end
        wr(7, 32'h1);
        set_rd(7, 0); #1;
        checks++; if (bus.rd_data[31:0] !== 32'h1) begin errors++; $display("FAIL rstclr_write got %h exp 1", bus.rd_data[31:0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            bus.wr_en   = $urandom_range(0, 1);
            bus.wr_src  = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 3'($urandom_range(0, D - 1));
            bus.wr_data = $urandom;
            bus.rd_addr = 6'($urandom_range(0, 63));
            bus.sb_set  = ($urandom_range(0, 2) == 0);
            bus.sb_addr = 3'($urandom_range(0, D - 1));
            bus.clr_req = ($urandom_range(0, 24) == 0);
            #1;
            for (int p = 0; p < R; p++) begin
                logic [2:0] a;
                a = bus.rd_addr[p*3 +: 3];
                checks++;
                if (bus.rd_data[p*W +: W] !== exp_rd(a) || bus.rd_pend[p] !== exp_pd(a)) begin
                    errors++; $display("FAIL rand_p%0d cyc%0d got %h/%b exp %h/%b", p, c, bus.rd_data[p*W +: W], bus.rd_pend[p], exp_rd(a), exp_pd(a));
                end
            end
            checks++;
            if (tap0 !== exp_rd(0) || tap1 !== exp_rd(1) || bus.clr_busy !== (clr_left > 0) || bus.wr_ready !== (clr_left == 0)) begin
                errors++; $display("FAIL rand_ctl cyc%0d taps %h %h busy %b ready %b exp %h %h %b %b", c, tap0, tap1, bus.clr_busy, bus.wr_ready, exp_rd(0), exp_rd(1), clr_left > 0, clr_left == 0);
            end
            tick();
        end
        rst = 0;
        idle_in();
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin mreg[i] = '0; msb[i] = 0; end
        test_reset();
        test_write_read();
        test_move();
        test_scoreboard();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file; successor to the fixed 8x32 two-bus file in the datapath.
- Adds a per-register pending-write scoreboard, a sequenced clear engine with handshake, and a register-to-register move path.
- Sits between decode/issue (scoreboard set, read addresses) and writeback (write port); exposes two architectural taps to the accumulator logic.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 8, number of registers; power of two, >= 2
- NUM_RD, 2, number of read ports, 1..4
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write request
- wr_ready  out  1  write accepted this cycle (low during clear)
- wr_addr  in  AW  write address
- wr_src  in  1  0 = write wr_data; 1 = move: write current read port 0 data
- wr_data  in  WIDTH  write data
- rd_addr  in  NUM_RD*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  packed read data
- rd_pend  out  NUM_RD  scoreboard bit of each addressed register
- sb_set  in  1  mark sb_addr pending (producer issued)
- sb_addr  in  AW  scoreboard set address
- clr_req  in  1  start sequenced clear (pulse or level)
- clr_busy  out  1  clear engine active
- tap0  out  WIDTH  register 0, always visible
- tap1  out  WIDTH  register 1, always visible

Behaviour:
- Single clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all registers 0, all scoreboard bits 0, FSM IDLE. Resulting outputs: clr_busy=0, wr_ready=1, tap0=tap1=0, rd_data=0, rd_pend=0.
- Reads: combinational from rd_addr; zero latency.
- Writes:
  - Accepted when wr_en && wr_ready; the register updates on the next clk edge.
  - A move (wr_src=1) writes the rd_data port-0 value sampled in that same cycle.
- Scoreboard:
  - sb_set sets bit[sb_addr]; an accepted write clears bit[wr_addr].
  - sb_set and an accepted write to the same address in the same cycle: set wins (bit=1).
  - sb_set to a different address: both take effect.
  - rd_pend[p] = bit[rd_addr[p]], combinational.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1; the index counter loads 0.
  - CLEAR: each cycle, reg[idx]=0 and bit[idx]=0, then idx++. Exit to IDLE after idx=DEPTH-1 is cleared, so CLEAR lasts exactly DEPTH cycles.
  - clr_busy=1 and wr_ready=0 throughout CLEAR.
  - wr_en during CLEAR is dropped, not queued; issue stalls on wr_ready.
  - sb_set during CLEAR is ignored.
  - clr_req held or re-asserted during CLEAR: no restart. If still high in the IDLE cycle, a new clear starts the following cycle.
  - The cycle after CLEAR ends is IDLE with wr_ready=1.
- rst mid-clear: IDLE next cycle; all state zero.
- Address wrap: idx counter is AW bits, with an explicit terminal compare to DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a port whose rd_addr equals wr_addr during an accepted write with wr_src=0 returns wr_data that same cycle, and its rd_pend returns 0 (unless sb_set hits the same address). Taps bypass likewise.
- Moves (wr_src=1) never bypass, which avoids the combinational loop; the port shows the pre-write value.
- Not defined: reads always return the stored (pre-write) value; rd_pend shows the stored bit.

Decomposition:
- Package regfile_pkg:
  - FSM state typedef (IDLE/CLEAR)
  - a function for packed-port slicing
  - default WIDTH/DEPTH constants
- Sub-module regfile_clr_seq: clear FSM plus index counter; outputs clr_busy, clr_idx, clr_we.
- Register array, scoreboard and read muxes stay in the top level.

Test Plan (DEPTH=8, WIDTH=32, NUM_RD=2):
- Write/read: write reg3=0xDEADBEEF, reg5=0x12345678; read p0=3, p1=5 next cycle -> 0xDEADBEEF / 0x12345678. tap0/tap1 unchanged at 0.
- Move: reg2=0xA5A5A5A5; wr_src=1, rd_addr p0=2, wr_addr=6 -> reg6=0xA5A5A5A5 next cycle; reg2 unchanged.
- Scoreboard:
  - sb_set reg4 -> rd_pend=1 on port reading 4.
  - Write reg4 -> rd_pend=0 next cycle.
  - Same-cycle sb_set and write to reg4 -> rd_pend stays 1.
- Clear:
  - Fill all 8 regs non-zero, set all pend bits, pulse clr_req -> clr_busy high for exactly 8 cycles, wr_ready low.
  - wr_en to reg1 mid-clear is dropped.
  - Afterwards all regs=0, all pend=0.
- Reset mid-clear: assert rst at clear cycle 3 -> next cycle clr_busy=0, all regs 0, FSM IDLE; a subsequent write reg7=0x1 succeeds.
- Bypass: write reg3=0xCAFEF00D with p1 reading 3 -> same-cycle rd_data p1 = 0xCAFEF00D if REGFILE_BYPASS_EN is defined, else the old value.
